// File: rtl/net_ni_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : net_ni_pkg
//  Description : Shared constants and helpers for the GPU network interface.
//                Holds the drop-counter width, the default broadcast-ID
//                generator and the flit field-extraction functions. The
//                functions work on a 32-bit container; callers size-cast the
//                flit in and the field out.
//  Revision    : 1.0  initial release
// ============================================================================
package net_ni_pkg;

    localparam int DROP_CNT_W = 16;

    // All-ones destination of the given width, used as the broadcast ID.
    function automatic logic [31:0] bcast_id_default(input int dest_w);
        if (dest_w >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << dest_w) - 32'd1;
    endfunction

    // Destination field: the dest_w bits sitting above the payload.
    function automatic logic [31:0] dest_of(input logic [31:0] flit,
                                            input int          dest_w,
                                            input int          pay_w);
        return (flit >> pay_w) & bcast_id_default(dest_w);
    endfunction

    // Payload field: the pay_w least-significant bits.
    function automatic logic [31:0] payload_of(input logic [31:0] flit,
                                               input int          pay_w);
        return flit & bcast_id_default(pay_w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/net_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : net_sync_fifo
//  Description : Single-clock FIFO with wrap-bit pointers. Full when the
//                pointer MSBs differ and the index bits match; empty when the
//                pointers are equal. Push and pop in the same cycle are legal
//                even at full (the pop frees the slot taken by the push).
//  Revision    : 1.0  initial release
//
//  Ports
//    ACLK        in   clock, rising edge
//    ARESETn     in   asynchronous active-low reset
//    push        in   write push_data (ignored when full and not popping)
//    push_data   in   WIDTH  data to write
//    pop         in   remove head (ignored when empty)
//    head        out  WIDTH  head entry; 0 while empty (FWFT build)
//    empty       out  FIFO holds no entries
//    not_full_q  out  registered not-full; 0 during reset and for the first
//                     cycle after release
//    level       out  $clog2(DEPTH)+1  occupancy
// ============================================================================
module net_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter bit FWFT  = 1'b1
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       empty,
    output logic                       not_full_q,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_full_lvl = (AW+1)'(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             r_not_full;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [AW:0]      w_wr_next;
    logic [AW:0]      w_rd_next;
    logic [AW:0]      w_level_next;

    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign empty   = (r_wr_ptr == r_rd_ptr);
    assign w_pop   = pop && !empty;
    // A push at full is only safe when the head leaves in the same cycle.
    assign w_push  = push && (!w_full || w_pop);

    assign w_wr_next    = r_wr_ptr + (AW+1)'(w_push);
    assign w_rd_next    = r_rd_ptr + (AW+1)'(w_pop);
    assign w_level_next = w_wr_next - w_rd_next;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_not_full <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_next;
            r_rd_ptr   <= w_rd_next;
            // Computed from the post-edge occupancy so the flag is never a
            // cycle stale and can gate upstream handshakes directly.
            r_not_full <= (w_level_next != c_full_lvl);
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= push_data;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign head = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
        end else begin : g_reg_out
            logic [WIDTH-1:0] r_head;
            always_ff @(posedge ACLK or negedge ARESETn) begin
                if (!ARESETn) begin
                    r_head <= '0;
                end else if (w_pop) begin
                    r_head <= r_mem[r_rd_ptr[AW-1:0]];
                end
            end
            assign head = r_head;
        end
    endgenerate

    assign not_full_q = r_not_full;
    assign level      = r_wr_ptr - r_rd_ptr;

endmodule
`default_nettype wire

// File: rtl/net_ni_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : net_ni_fifo
//  Description : GPU network interface. Local packets are queued in a TX FIFO
//                and streamed onto the NoC link (first-word fall-through).
//                Incoming flits addressed to NODE_ID or BCAST_ID are queued in
//                an RX FIFO for the core; all other consumed flits are dropped
//                and counted (saturating).
//                Build option NET_NI_FWD_EN: non-matching flits are forwarded
//                through a 1-entry register into the TX FIFO (ring topology),
//                with priority over local traffic; the drop counter then only
//                counts flits refused because the forward path is blocked.
//  Revision    : 1.0  initial release
//
//  Ports
//    ACLK, ARESETn                clock / asynchronous active-low reset
//    tx_dest, tx_payload          local packet fields
//    tx_valid / tx_ready          local packet handshake
//    net_data_out/net_valid_out   flit to NoC {dest,payload}
//    net_ready_in                 NoC accepts flit
//    net_data_in/net_valid_in     flit from NoC
//    net_ready_out                NI accepts incoming flit
//    rx_payload/rx_valid          RX FIFO head to core
//    rx_ready                     core pops RX head
//    tx_level, rx_level           FIFO occupancies
//    rx_drop_cnt                  saturating dropped-flit count
// ============================================================================
module net_ni_fifo
    import net_ni_pkg::*;
#(
    parameter int                NODE_ID  = 9,
    parameter int                DEST_W   = 6,
    parameter int                PAY_W    = 10,
    parameter int                TX_DEPTH = 4,
    parameter int                RX_DEPTH = 4,
    parameter logic [DEST_W-1:0] BCAST_ID = DEST_W'(bcast_id_default(DEST_W)),
    localparam int               FLIT_W   = DEST_W + PAY_W
) (
    input  logic                        ACLK,
    input  logic                        ARESETn,
    input  logic [DEST_W-1:0]           tx_dest,
    input  logic [PAY_W-1:0]            tx_payload,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic [FLIT_W-1:0]           net_data_out,
    output logic                        net_valid_out,
    input  logic                        net_ready_in,
    input  logic [FLIT_W-1:0]           net_data_in,
    input  logic                        net_valid_in,
    output logic                        net_ready_out,
    output logic [PAY_W-1:0]            rx_payload,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic [$clog2(TX_DEPTH):0]   tx_level,
    output logic [$clog2(RX_DEPTH):0]   rx_level,
    output logic [DROP_CNT_W-1:0]       rx_drop_cnt
);

    logic                  w_tx_push;
    logic [FLIT_W-1:0]     w_tx_push_data;
    logic                  w_tx_empty;
    logic                  w_tx_nf_q;
    logic                  w_rx_empty;
    logic                  w_rx_nf_q;
    logic [DEST_W-1:0]     w_in_dest;
    logic [PAY_W-1:0]      w_in_pay;
    logic                  w_in_take;
    logic                  w_match;
    logic                  w_drop_evt;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    // ---------------------------------------------------------------- TX ----
    net_sync_fifo #(
        .WIDTH (FLIT_W),
        .DEPTH (TX_DEPTH),
        .FWFT  (1'b1)
    ) u_tx_fifo (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .push       (w_tx_push),
        .push_data  (w_tx_push_data),
        .pop        (net_valid_out && net_ready_in),
        .head       (net_data_out),
        .empty      (w_tx_empty),
        .not_full_q (w_tx_nf_q),
        .level      (tx_level)
    );

    assign net_valid_out = !w_tx_empty;

    // ------------------------------------------------------- RX filter ----
    assign w_in_dest = DEST_W'(dest_of(32'(net_data_in), DEST_W, PAY_W));
    assign w_in_pay  = PAY_W'(payload_of(32'(net_data_in), PAY_W));
    assign w_match   = (w_in_dest == DEST_W'(NODE_ID)) || (w_in_dest == BCAST_ID);
    assign w_in_take = net_valid_in && net_ready_out;

    net_sync_fifo #(
        .WIDTH (PAY_W),
        .DEPTH (RX_DEPTH),
        .FWFT  (1'b1)
    ) u_rx_fifo (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .push       (w_in_take && w_match),
        .push_data  (w_in_pay),
        .pop        (rx_valid && rx_ready),
        .head       (rx_payload),
        .empty      (w_rx_empty),
        .not_full_q (w_rx_nf_q),
        .level      (rx_level)
    );

    assign rx_valid = !w_rx_empty;

`ifdef NET_NI_FWD_EN
    // ------------------------------------------------- forward path ----
    localparam int              TX_AW         = $clog2(TX_DEPTH);
    localparam logic [TX_AW:0]  c_tx_full_lvl = (TX_AW+1)'(TX_DEPTH);

    logic              r_fwd_valid;
    logic [FLIT_W-1:0] r_fwd_flit;
    logic              w_tx_full;
    logic              w_fwd_push;
    logic              w_fwd_block;
    logic              w_fwd_load;

    assign w_tx_full   = (tx_level == c_tx_full_lvl);
    // Forwarded traffic wins the TX push port whenever it has room.
    assign w_fwd_push  = r_fwd_valid && !w_tx_full;
    // Register occupied and unable to drain: no room for another flit.
    assign w_fwd_block = r_fwd_valid && w_tx_full;
    assign w_fwd_load  = w_in_take && !w_match;

    assign tx_ready       = w_tx_nf_q && !w_fwd_push;
    assign w_tx_push      = w_fwd_push || (tx_valid && tx_ready);
    assign w_tx_push_data = w_fwd_push ? r_fwd_flit : {tx_dest, tx_payload};
    assign net_ready_out  = w_rx_nf_q && !w_fwd_block;
    assign w_drop_evt     = net_valid_in && !w_match && w_rx_nf_q && w_fwd_block;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_fwd_valid <= 1'b0;
            r_fwd_flit  <= '0;
        end else if (w_fwd_load) begin
            // A load while the old entry drains this cycle is a hand-over.
            r_fwd_valid <= 1'b1;
            r_fwd_flit  <= net_data_in;
        end else if (w_fwd_push) begin
            r_fwd_valid <= 1'b0;
        end
    end
`else
    assign tx_ready       = w_tx_nf_q;
    assign w_tx_push      = tx_valid && tx_ready;
    assign w_tx_push_data = {tx_dest, tx_payload};
    assign net_ready_out  = w_rx_nf_q;
    // Non-matching flits are still consumed so they never stall the link.
    assign w_drop_evt     = w_in_take && !w_match;
`endif

    // ------------------------------------------------ drop counter ----
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_drop_cnt <= '0;
        end else if (w_drop_evt && (r_drop_cnt != {DROP_CNT_W{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
        end
    end

    assign rx_drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_net_ni_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_net_ni_fifo
//  Description : Self-checking bench for net_ni_fifo (default parameters).
//                Table-driven vectors for single packets and RX filtering,
//                hand-written sequences for backpressure, RX full, counter
//                saturation and reset mid-traffic. Scoreboard queues hold the
//                expected NoC flits and RX payloads in order.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_net_ni_fifo;

    logic        ACLK;
    logic        ARESETn;
    logic [5:0]  tx_dest;
    logic [9:0]  tx_payload;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] net_data_out;
    logic        net_valid_out;
    logic        net_ready_in;
    logic [15:0] net_data_in;
    logic        net_valid_in;
    logic        net_ready_out;
    logic [9:0]  rx_payload;
    logic        rx_valid;
    logic        rx_ready;
    logic [2:0]  tx_level;
    logic [2:0]  rx_level;
    logic [15:0] rx_drop_cnt;

    net_ni_fifo dut (
        .ACLK          (ACLK),
        .ARESETn       (ARESETn),
        .tx_dest       (tx_dest),
        .tx_payload    (tx_payload),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .net_data_out  (net_data_out),
        .net_valid_out (net_valid_out),
        .net_ready_in  (net_ready_in),
        .net_data_in   (net_data_in),
        .net_valid_in  (net_valid_in),
        .net_ready_out (net_ready_out),
        .rx_payload    (rx_payload),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .tx_level      (tx_level),
        .rx_level      (rx_level),
        .rx_drop_cnt   (rx_drop_cnt)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [15:0] tx_exp_q[$];
    logic [9:0]  rx_exp_q[$];
    logic [15:0] drop_model = 16'd0;

    typedef struct packed {
        logic [5:0]  dest;
        logic [9:0]  pay;
        logic [15:0] exp_flit;
    } tx_vec_t;

    typedef struct packed {
        logic [5:0] dest;
        logic [9:0] pay;
        logic       match;
    } rx_vec_t;

    tx_vec_t tx_vec[5];
    rx_vec_t rx_vec[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Scoreboard monitor: sampled mid-cycle, so every handshake seen here
    // completes on the following rising edge.
    always @(negedge ACLK) begin
        if (!ARESETn) begin
            tx_exp_q.delete();
            rx_exp_q.delete();
            drop_model = 16'd0;
        end else begin
            if (net_valid_out && net_ready_in) begin
                if (tx_exp_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL tx_unexpected: flit 0x%0h emitted, none expected", net_data_out);
                end else begin
                    check("tx_flit_order", net_data_out, tx_exp_q.pop_front());
                end
            end
            if (rx_valid && rx_ready) begin
                if (rx_exp_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL rx_unexpected: payload 0x%0h popped, none expected", rx_payload);
                end else begin
                    check("rx_payload_order", rx_payload, rx_exp_q.pop_front());
                end
            end
            if (tx_valid && tx_ready) begin
                tx_exp_q.push_back({tx_dest, tx_payload});
            end
            if (net_valid_in && net_ready_out) begin
                if (net_data_in[15:10] == 6'd9 || net_data_in[15:10] == 6'd63) begin
                    rx_exp_q.push_back(net_data_in[9:0]);
                end else begin
`ifdef NET_NI_FWD_EN
                    tx_exp_q.push_back(net_data_in);
`else
                    if (drop_model != 16'hFFFF) drop_model = drop_model + 16'd1;
`endif
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int exp_lvl;

        tx_vec[0] = '{dest: 6'd10, pay: 10'h123, exp_flit: 16'h2923};
        tx_vec[1] = '{dest: 6'd0,  pay: 10'h000, exp_flit: 16'h0000};
        tx_vec[2] = '{dest: 6'd63, pay: 10'h3FF, exp_flit: 16'hFFFF};
        tx_vec[3] = '{dest: 6'd1,  pay: 10'h001, exp_flit: 16'h0401};
        tx_vec[4] = '{dest: 6'd33, pay: 10'h2AA, exp_flit: 16'h86AA};

        rx_vec[0] = '{dest: 6'd9,  pay: 10'h055, match: 1'b1};
        rx_vec[1] = '{dest: 6'd63, pay: 10'h0AA, match: 1'b1};
        rx_vec[2] = '{dest: 6'd5,  pay: 10'h1FF, match: 1'b0};

        ARESETn      = 1'b0;
        tx_dest      = '0;
        tx_payload   = '0;
        tx_valid     = 1'b0;
        net_ready_in = 1'b0;
        net_data_in  = '0;
        net_valid_in = 1'b0;
        rx_ready     = 1'b0;

        // ---------------- reset state
        repeat (2) @(posedge ACLK);
        #1;
        check("rst_tx_ready",      tx_ready,      0);
        check("rst_net_valid_out", net_valid_out, 0);
        check("rst_net_data_out",  net_data_out,  0);
        check("rst_net_ready_out", net_ready_out, 0);
        check("rst_rx_valid",      rx_valid,      0);
        check("rst_rx_payload",    rx_payload,    0);
        check("rst_tx_level",      tx_level,      0);
        check("rst_rx_level",      rx_level,      0);
        check("rst_drop_cnt",      rx_drop_cnt,   0);

        @(negedge ACLK);
        ARESETn = 1'b1;
        #1;
        check("rel_tx_ready_pre_edge", tx_ready, 0);
        tick();
        check("rel_tx_ready",      tx_ready,      1);
        check("rel_net_ready_out", net_ready_out, 1);

        // ---------------- single packets (table)
        net_ready_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tx_dest    = tx_vec[i].dest;
            tx_payload = tx_vec[i].pay;
            tx_valid   = 1'b1;
            tick();
            tx_valid = 1'b0;
            check("t1_valid",  net_valid_out, 1);
            check("t1_data",   net_data_out,  tx_vec[i].exp_flit);
            check("t1_level1", tx_level,      1);
            tick();
            check("t1_valid_one_cycle", net_valid_out, 0);
            check("t1_level0",          tx_level,      0);
        end

        // ---------------- backpressure
        net_ready_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tx_dest    = 6'(i + 1);
            tx_payload = 10'(10'h0A0 + i);
            tx_valid   = 1'b1;
            tick();
        end
        check("t2_tx_ready_full", tx_ready,      0);
        check("t2_level_full",    tx_level,      4);
        check("t2_head_valid",    net_valid_out, 1);
        check("t2_head_data",     net_data_out,  16'h04A0);
        tx_dest    = 6'd40;
        tx_payload = 10'h3CC;
        tick();
        tx_valid = 1'b0;
        check("t2_level_no_overflow", tx_level, 4);
        net_ready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t2_stream_valid", net_valid_out, 1);
            tick();
        end
        check("t2_drained_valid", net_valid_out, 0);
        check("t2_drained_level", tx_level,      0);
        check("t2_tx_ready_back", tx_ready,      1);

        // ---------------- RX filtering (table)
        net_ready_in = 1'b0;
        rx_ready     = 1'b0;
        exp_lvl      = 0;
        for (int i = 0; i < 3; i++) begin
            check("t3_ready_in", net_ready_out, 1);
            net_data_in  = {rx_vec[i].dest, rx_vec[i].pay};
            net_valid_in = 1'b1;
            tick();
            if (rx_vec[i].match) exp_lvl++;
            check("t3_rx_level", rx_level, exp_lvl);
        end
        net_valid_in = 1'b0;
        check("t3_rx_valid", rx_valid,   1);
        check("t3_rx_head",  rx_payload, 10'h055);
`ifdef NET_NI_FWD_EN
        check("t3_drop_cnt", rx_drop_cnt, 0);
        tick();
        check("t3_fwd_valid", net_valid_out, 1);
        check("t3_fwd_data",  net_data_out,  16'h15FF);
        net_ready_in = 1'b1;
        tick();
        net_ready_in = 1'b0;
`else
        check("t3_drop_cnt", rx_drop_cnt, 1);
        check("t3_no_tx",    net_valid_out, 0);
`endif
        rx_ready = 1'b1;
        tick();
        tick();
        rx_ready = 1'b0;
        check("t3_rx_empty", rx_valid, 0);
        check("t3_rx_lvl0",  rx_level, 0);

        // ---------------- RX full
        for (int i = 0; i < 4; i++) begin
            check("t4_ready_before_full", net_ready_out, 1);
            net_data_in  = {((i % 2) == 1) ? 6'd63 : 6'd9, 10'(10'h300 + i)};
            net_valid_in = 1'b1;
            tick();
        end
        check("t4_ready_full", net_ready_out, 0);
        check("t4_level_full", rx_level,      4);
        net_data_in = {6'd9, 10'h3AA};
        tick();
        tick();
        check("t4_fifth_held_ready", net_ready_out, 0);
        check("t4_fifth_held_level", rx_level,      4);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check("t4_after_pop_level", rx_level,      3);
        check("t4_after_pop_ready", net_ready_out, 1);
        tick();
        net_valid_in = 1'b0;
        check("t4_fifth_accepted", rx_level,      4);
        check("t4_full_again",     net_ready_out, 0);
        rx_ready = 1'b1;
        n = 0;
        while (rx_valid && n < 10) begin
            tick();
            n++;
        end
        rx_ready = 1'b0;
        check("t4_drained",      rx_valid, 0);
        check("t4_drained_lvl0", rx_level, 0);

`ifndef NET_NI_FWD_EN
        // ---------------- drop counter saturation
        net_data_in  = {6'd5, 10'h111};
        net_valid_in = 1'b1;
        repeat (65537) @(posedge ACLK);
        #1;
        net_valid_in = 1'b0;
        check("t5_sat_value", rx_drop_cnt, 16'hFFFF);
        check("t5_sat_model", rx_drop_cnt, drop_model);
        check("t5_rx_untouched", rx_level, 0);
        tick();
        check("t5_no_wrap", rx_drop_cnt, 16'hFFFF);
`endif

        // ---------------- reset mid-traffic
        net_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tx_dest    = 6'(i + 20);
            tx_payload = 10'(10'h050 + i);
            tx_valid   = 1'b1;
            tick();
        end
        tx_valid = 1'b0;
        check("t6_level3",       tx_level,      3);
        check("t6_valid_before", net_valid_out, 1);
        #2;
        ARESETn = 1'b0;
        #1;
        check("t6_async_valid",   net_valid_out, 0);
        check("t6_async_data",    net_data_out,  0);
        check("t6_async_level",   tx_level,      0);
        check("t6_async_txready", tx_ready,      0);
        check("t6_async_drop",    rx_drop_cnt,   0);
        net_ready_in = 1'b1;
        @(negedge ACLK);
        @(negedge ACLK);
        ARESETn = 1'b1;
        repeat (5) tick();
        check("t6_post_tx_level", tx_level,      0);
        check("t6_post_rx_level", rx_level,      0);
        check("t6_post_no_flit",  net_valid_out, 0);
        check("t6_post_txready",  tx_ready,      1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/net_ni_fifo.md
Name: net_ni_fifo

Overview:
- Parametrised GPU network interface. Buffers locally generated packets in a TX FIFO and drives them onto the 16-bit-class NoC link.
- Filters incoming flits by destination ID and buffers accepted payloads in an RX FIFO for the GPU core.
- Supersedes the single-register, one-flit-at-a-time NI. Adds valid/ready flow control on both sides, configurable depths, broadcast, drop accounting and optional forwarding.

Parameters:
- NODE_ID, 9, this node's destination ID.
- DEST_W, 6, destination field width (flit MSBs).
- PAY_W, 10, payload width (flit LSBs); FLIT_W = DEST_W+PAY_W.
- TX_DEPTH, 4, TX FIFO entries, power of two, ≥2.
- RX_DEPTH, 4, RX FIFO entries, power of two, ≥2.
- BCAST_ID, all-ones of DEST_W, destination accepted by every node.

Ports:
- ACLK  in  1  clock, all logic on rising edge.
- ARESETn  in  1  asynchronous active-low reset.
- tx_dest  in  DEST_W  destination of local packet.
- tx_payload  in  PAY_W  local packet payload.
- tx_valid  in  1  local packet offered.
- tx_ready  out  1  TX FIFO not full.
- net_data_out  out  FLIT_W  flit to NoC, {dest,payload}.
- net_valid_out  out  1  flit valid.
- net_ready_in  in  1  NoC accepts flit.
- net_data_in  in  FLIT_W  flit from NoC.
- net_valid_in  in  1  incoming flit valid.
- net_ready_out  out  1  NI accepts incoming flit.
- rx_payload  out  PAY_W  head of RX FIFO.
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  core pops RX head.
- tx_level  out  $clog2(TX_DEPTH)+1  TX occupancy.
- rx_level  out  $clog2(RX_DEPTH)+1  RX occupancy.
- rx_drop_cnt  out  16  saturating count of dropped flits.

Behaviour:
- Reset (async, ARESETn=0):
  - FIFOs empty; pointers 0; net_valid_out=0; net_data_out=0.
  - rx_valid=0; rx_payload=0; tx_ready=0.
  - net_ready_out=0; levels 0; rx_drop_cnt=0.
  - tx_ready and net_ready_out go to 1 on the first clock after reset release.
- FIFOs: registered pointers with extra wrap bit; full when MSBs differ and LSBs match; empty when pointers are equal. Push and pop in the same cycle are legal and leave the level unchanged, including at full (pop frees the slot, push accepted; tx_ready stays 1 for that case only when not full at cycle start).
- TX push: tx_valid&&tx_ready writes {tx_dest,tx_payload}. tx_ready = !tx_full (registered, updated every cycle).
- TX output:
  - net_data_out/net_valid_out show the FIFO head combinationally (first-word fall-through); 0-cycle latency from non-empty to valid.
  - Pop on net_valid_out&&net_ready_in.
  - Once asserted, net_data_out holds stable until the handshake.
- RX filter: flit accepted when net_valid_in&&net_ready_out and dest==NODE_ID or dest==BCAST_ID. Accepted payload is pushed into the RX FIFO and becomes visible one cycle later.
- net_ready_out = !rx_full, registered. Non-matching flits are always consumed when net_ready_out=1: dropped, counter incremented.
- rx_drop_cnt: increments on each non-matching consumed flit; saturates at 16'hFFFF and does not wrap.
- RX output: rx_valid=!rx_empty; rx_payload=head; pop on rx_valid&&rx_ready.
- Simultaneous events: RX push and pop in one cycle are handled as for the FIFOs. A matching flit arriving while the RX FIFO becomes not-full in the same cycle waits for the next cycle's net_ready_out.
- Reset mid-transfer: in-flight entries are discarded; no partial flit is emitted.

Optional Feature:
- Macro NET_NI_FWD_EN.
- Defined:
  - Non-matching flits are forwarded into the TX path instead of dropped (ring topology).
  - A 1-entry forward register feeds a 2:1 arbiter in front of the TX FIFO push; forward traffic has priority.
  - tx_ready=0 in any cycle the forward register pushes.
  - rx_drop_cnt counts only flits refused because the forward register is occupied and the TX FIFO is full. net_ready_out also deasserts in that case.
- Undefined: drop behaviour exactly as above; no forward register.

Decomposition:
- Package net_ni_pkg:
  - flit field-extraction functions (dest_of, payload_of)
  - DROP_CNT_W=16
  - default BCAST_ID helper
- One sub-module, net_sync_fifo (parametrised WIDTH, DEPTH, FWFT, level output), instantiated twice: TX width FLIT_W, RX width PAY_W.

Test Plan:
- Single packet: push tx_dest=10, tx_payload=0x123 with net_ready_in=1 -> next cycle net_data_out=16'h2923, net_valid_out=1 for one cycle, tx_level returns to 0.
- Backpressure: net_ready_in=0, push 4 packets -> tx_ready=0 after 4th, tx_level=4. Release -> 4 flits emitted in push order on consecutive cycles.
- Filtering: send {9,0x055}, {63,0x0AA}, {5,0x1FF} -> RX FIFO holds 0x055 then 0x0AA; rx_drop_cnt=1 (0 with NET_NI_FWD_EN, and 0x1FF reappears on net_data_out).
- RX full: rx_ready=0, send 5 matching flits -> net_ready_out=0 after 4 accepted, 5th held. Pop one -> 5th accepted next cycle.
- Saturation: force 65537 non-matching flits -> rx_drop_cnt=16'hFFFF.
- Reset mid-traffic: assert ARESETn=0 with TX level 3 -> net_valid_out=0 immediately (async). After release, levels are 0 and no stale flit is emitted.
